// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, legal-op bound and arbiter state encoding
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_SLL  = 5'b00010,
    OP_SLT  = 5'b00011,
    OP_SLTU = 5'b00100,
    OP_XOR  = 5'b00101,
    OP_SRL  = 5'b00110,
    OP_SRA  = 5'b00111,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01001
  } aluop_e;

  localparam logic [4:0] LAST_LEGAL_OP = 5'b01001;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester ALU request bus plus registered response channel
interface alu_arbiter_if;

  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic [4:0]  r0_op;
  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [4:0]  r1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic        rsp_src;
  logic        rsp_err;

  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    output r1_valid, r1_a, r1_b, r1_op,
    output rsp_ready,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_y, rsp_zero, rsp_src, rsp_err
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    input  r1_valid, r1_a, r1_b, r1_op,
    input  rsp_ready,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_y, rsp_zero, rsp_src, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU; illegal ops yield zero
module alu
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUop,
  output logic [31:0] Y,
  output logic        zero
);

  always_comb begin
    Y = 32'h0;
    case (ALUop)
      OP_ADD:  Y = A + B;
      OP_SUB:  Y = A - B;
      OP_SLL:  Y = A << B[4:0];
      OP_SLT:  Y = {31'h0, $signed(A) < $signed(B)};
      OP_SLTU: Y = {31'h0, A < B};
      OP_XOR:  Y = A ^ B;
      OP_SRL:  Y = A >> B[4:0];
      OP_SRA:  Y = $unsigned($signed(A) >>> B[4:0]);
      OP_OR:   Y = A | B;
      OP_AND:  Y = A & B;
      default: Y = 32'h0;
    endcase
  end

  assign zero = (Y == 32'h0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-way arbiter in front of one shared ALU with a single response register
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_e      state;
  state_e      state_nxt;
  logic        last_gnt;
  logic        slot_free;
  logic        gnt_idx;
  logic        gnt_any;
  logic [31:0] a_sel;
  logic [31:0] b_sel;
  logic [4:0]  op_sel;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic [31:0] rsp_y_q;
  logic        rsp_zero_q;
  logic        rsp_src_q;
  logic        rsp_err_q;

  // Grant choice depends only on valids and pointer, never on operand data.
  always_comb begin
    slot_free = (state == EMPTY) || bus.rsp_ready;
    if (bus.r0_valid && bus.r1_valid)
      gnt_idx = RR_EN ? ~last_gnt : 1'b0;
    else
      gnt_idx = bus.r1_valid;
    gnt_any      = !rst && slot_free && (bus.r0_valid || bus.r1_valid);
    bus.r0_ready = gnt_any && !gnt_idx;
    bus.r1_ready = gnt_any && gnt_idx;
  end

  always_comb begin
    state_nxt = state;
    if (gnt_any)
      state_nxt = FULL;
    else if (state == FULL && bus.rsp_ready)
      state_nxt = EMPTY;
  end

  assign a_sel  = gnt_idx ? bus.r1_a  : bus.r0_a;
  assign b_sel  = gnt_idx ? bus.r1_b  : bus.r0_b;
  assign op_sel = gnt_idx ? bus.r1_op : bus.r0_op;

  alu u_alu (
    .A     (a_sel),
    .B     (b_sel),
    .ALUop (op_sel),
    .Y     (alu_y),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      last_gnt   <= 1'b1;
      rsp_y_q    <= 32'h0;
      rsp_zero_q <= 1'b0;
      rsp_src_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        last_gnt   <= gnt_idx;
        rsp_y_q    <= alu_y;
        rsp_zero_q <= alu_zero;
        rsp_src_q  <= gnt_idx;
        rsp_err_q  <= (op_sel > LAST_LEGAL_OP);
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed checks of round-robin and fixed-priority ALU arbiter builds
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_arbiter_if b1 ();
  alu_arbiter_if b0 ();

  alu_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(b1.slave));
  alu_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(b0.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b1.r0_valid = 1'b1; b1.r0_a = 32'h0; b1.r0_b = 32'h0; b1.r0_op = OP_ADD;
    b1.r1_valid = 1'b1; b1.r1_a = 32'h0; b1.r1_b = 32'h0; b1.r1_op = OP_ADD;
    b1.rsp_ready = 1'b1;
    b0.r0_valid = 1'b0; b0.r0_a = 32'h0; b0.r0_b = 32'h0; b0.r0_op = OP_ADD;
    b0.r1_valid = 1'b0; b0.r1_a = 32'h0; b0.r1_b = 32'h0; b0.r1_op = OP_ADD;
    b0.rsp_ready = 1'b1;

    // Reset: readies held low, response register cleared
    #1;
    chk("rst_r0_ready", b1.r0_ready, 1'b0);
    chk("rst_r1_ready", b1.r1_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    b1.r0_valid = 1'b0; b1.r1_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", b1.rsp_valid, 1'b0);
    chk("rst_rsp_y", b1.rsp_y, 32'h0);
    chk("rst_rsp_zero", b1.rsp_zero, 1'b0);
    chk("rst_rsp_src", b1.rsp_src, 1'b0);
    chk("rst_rsp_err", b1.rsp_err, 1'b0);
    chk("fp_rst_rsp_valid", b0.rsp_valid, 1'b0);
    tick();

    // r0 alone: ADD 0x10 + 0x20, one-cycle latency
    b1.r0_valid = 1'b1; b1.r0_a = 32'h10; b1.r0_b = 32'h20; b1.r0_op = OP_ADD;
    #1;
    chk("add_r0_ready", b1.r0_ready, 1'b1);
    chk("add_r1_ready", b1.r1_ready, 1'b0);
    tick();
    b1.r0_valid = 1'b0;
    chk("add_rsp_valid", b1.rsp_valid, 1'b1);
    chk("add_rsp_y", b1.rsp_y, 32'h30);
    chk("add_rsp_src", b1.rsp_src, 1'b0);
    chk("add_rsp_zero", b1.rsp_zero, 1'b0);
    chk("add_rsp_err", b1.rsp_err, 1'b0);
    tick();
    chk("add_drain", b1.rsp_valid, 1'b0);

    // r1 SUB with consumer stalled for 3 cycles
    b1.rsp_ready = 1'b0;
    b1.r1_valid = 1'b1; b1.r1_a = 32'h10; b1.r1_b = 32'h10; b1.r1_op = OP_SUB;
    #1;
    chk("sub_r1_ready", b1.r1_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rsp_valid", b1.rsp_valid, 1'b1);
      chk("stall_rsp_y", b1.rsp_y, 32'h0);
      chk("stall_rsp_zero", b1.rsp_zero, 1'b1);
      chk("stall_rsp_src", b1.rsp_src, 1'b1);
      chk("stall_r0_ready", b1.r0_ready, 1'b0);
      chk("stall_r1_ready", b1.r1_ready, 1'b0);
    end
    b1.r1_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    tick();
    chk("stall_single_rsp", b1.rsp_valid, 1'b0);

    // Both valid, round robin: grants 0,1,0,1 and back-to-back responses
    b1.r0_valid = 1'b1; b1.r0_a = 32'h1;  b1.r0_b = 32'h2;  b1.r0_op = OP_ADD;
    b1.r1_valid = 1'b1; b1.r1_a = 32'ha;  b1.r1_b = 32'h14; b1.r1_op = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_r0_ready", b1.r0_ready, (i % 2) == 0);
      chk("rr_r1_ready", b1.r1_ready, (i % 2) == 1);
      tick();
      chk("rr_rsp_valid", b1.rsp_valid, 1'b1);
      chk("rr_rsp_src", b1.rsp_src, (i % 2) == 1);
      chk("rr_rsp_y", b1.rsp_y, ((i % 2) == 1) ? 32'h1e : 32'h3);
    end
    b1.r0_valid = 1'b0; b1.r1_valid = 1'b0;
    tick();
    chk("rr_drain", b1.rsp_valid, 1'b0);

    // Illegal op, then SRA issued in the very next cycle
    b1.r0_valid = 1'b1; b1.r0_a = 32'h5; b1.r0_b = 32'h7; b1.r0_op = 5'b01111;
    #1;
    chk("ill_r0_ready", b1.r0_ready, 1'b1);
    tick();
    chk("ill_rsp_err", b1.rsp_err, 1'b1);
    chk("ill_rsp_y", b1.rsp_y, 32'h0);
    chk("ill_rsp_zero", b1.rsp_zero, 1'b1);
    b1.r0_a = 32'h8000_0000; b1.r0_b = 32'h2; b1.r0_op = OP_SRA;
    #1;
    chk("sra_r0_ready", b1.r0_ready, 1'b1);
    tick();
    b1.r0_valid = 1'b0;
    chk("sra_rsp_valid", b1.rsp_valid, 1'b1);
    chk("sra_rsp_y", b1.rsp_y, 32'he000_0000);
    chk("sra_rsp_err", b1.rsp_err, 1'b0);
    chk("sra_rsp_zero", b1.rsp_zero, 1'b0);
    tick();
    chk("sra_drain", b1.rsp_valid, 1'b0);

    // Fixed-priority build: requester 0 wins every tie
    b0.r0_valid = 1'b1; b0.r0_a = 32'h4; b0.r0_b = 32'h4; b0.r0_op = OP_ADD;
    b0.r1_valid = 1'b1; b0.r1_a = 32'h7; b0.r1_b = 32'h1; b0.r1_op = OP_XOR;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_r0_ready", b0.r0_ready, 1'b1);
      chk("fp_r1_ready", b0.r1_ready, 1'b0);
      tick();
      chk("fp_rsp_src", b0.rsp_src, 1'b0);
      chk("fp_rsp_y", b0.rsp_y, 32'h8);
    end
    b0.r0_valid = 1'b0; b0.r1_valid = 1'b0;

    // Reset while FULL, then first tie goes to requester 0
    b1.rsp_ready = 1'b0;
    b1.r0_valid = 1'b1; b1.r0_a = 32'h1; b1.r0_b = 32'h2; b1.r0_op = OP_ADD;
    tick();
    chk("pre_rst_full", b1.rsp_valid, 1'b1);
    b1.r0_valid = 1'b1; b1.r1_valid = 1'b1;
    b1.r1_a = 32'h3; b1.r1_b = 32'h3; b1.r1_op = OP_OR;
    b1.rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("full_rst_r0_ready", b1.r0_ready, 1'b0);
    chk("full_rst_r1_ready", b1.r1_ready, 1'b0);
    tick();
    rst = 1'b0;
    chk("post_rst_rsp_valid", b1.rsp_valid, 1'b0);
    chk("post_rst_rsp_y", b1.rsp_y, 32'h0);
    chk("post_rst_rsp_zero", b1.rsp_zero, 1'b0);
    chk("post_rst_rsp_src", b1.rsp_src, 1'b0);
    chk("post_rst_rsp_err", b1.rsp_err, 1'b0);
    #1;
    chk("post_rst_tie_r0", b1.r0_ready, 1'b1);
    chk("post_rst_tie_r1", b1.r1_ready, 1'b0);
    tick();
    chk("post_rst_src", b1.rsp_src, 1'b0);
    chk("post_rst_y", b1.rsp_y, 32'h3);
    b1.r0_valid = 1'b0; b1.r1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 highest.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports r0_valid and r1_valid, input, 1 bit each: requester N presents an operation.
REQ-005 The block SHALL have ports r0_ready and r1_ready, output, 1 bit each: requester N's operation is accepted this cycle.
REQ-006 The block SHALL have ports r0_a, r0_b, r1_a and r1_b, input, 32 bits each: operands A and B.
REQ-007 The block SHALL have ports r0_op and r1_op, input, 5 bits each: ALUop (ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001).
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: the response register holds a result.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-010 The block SHALL have port rsp_y, output, 32 bits: the registered ALU result.
REQ-011 The block SHALL have port rsp_zero, output, 1 bit: the registered zero flag (rsp_y == 0).
REQ-012 The block SHALL have port rsp_src, output, 1 bit: the index of the requester that produced the response.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the op was outside 00000..01001.

Function
REQ-014 The block SHALL implement two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 The block SHALL define slot_free = EMPTY or (FULL and rsp_ready).
REQ-016 The block SHALL assert at most one of r0_ready/r1_ready per cycle, and only when slot_free and the corresponding rN_valid are both 1.
REQ-017 In combinational request-to-ready paths, the block SHALL make rN_ready independent of rN_a, rN_b and rN_op.
REQ-018 When only one requester is valid, the block SHALL grant that requester.
REQ-019 When both requesters are valid and RR_EN=1, the block SHALL grant the requester not granted last; the last-grant pointer updates only on acceptance.
REQ-020 When both requesters are valid and RR_EN=0, the block SHALL grant requester 0.
REQ-021 On acceptance, the block SHALL pass the granted operands and op through one shared ALU instance and register Y, zero, the grant index and the error flag into rsp_*; the state becomes FULL.
REQ-022 The block SHALL have a latency of 1: a request accepted in cycle N yields rsp_valid=1 in cycle N+1.
REQ-023 In FULL without rsp_ready, the block SHALL hold rsp_* stable and keep both rN_ready=0.
REQ-024 On a response handshake with no new grant, the block SHALL return to EMPTY.
REQ-025 On a response handshake and a new grant in the same cycle, the block SHALL stay FULL with the new result (throughput 1 op/cycle).
REQ-026 For an illegal op (01010..11111), the block SHALL produce rsp_y=0, rsp_zero=1 and rsp_err=1; such requests are still accepted and responded to.
REQ-027 The block SHALL use no arithmetic beyond the ALU; shift amounts use B[4:0] as defined by the ALU.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set the state to EMPTY, rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_src=0, rsp_err=0, and the last-grant pointer to 1 (so requester 0 wins the first tie).
REQ-029 During reset cycles, the block SHALL hold r0_ready=r1_ready=0.
REQ-030 Reset asserted while FULL SHALL discard the held response without a handshake.

Structure
REQ-031 The ALUop encodings, the last-legal-op constant (01001) and the state encoding SHALL live in shared package alu_pkg.
REQ-032 The block SHALL instantiate exactly one existing ALU sub-module (ALU: A, B, ALUop, Y, zero) and no other sub-modules.

Verification
REQ-033 The bench SHALL drive r0 only with ADD 0x10, 0x20 -> r0_ready=1 for that cycle, and next cycle rsp_valid=1, rsp_y=0x30, rsp_src=0, rsp_zero=0.
REQ-034 The bench SHALL drive r0 and r1 valid continuously with RR_EN=1 and rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, and rsp_valid stays high every cycle.
REQ-035 The bench SHALL drive r1 with SUB 0x10, 0x10 while rsp_ready=0 for 3 cycles -> rsp_y=0, rsp_zero=1 held for 3 cycles, both readys 0, and a single response only.
REQ-036 The bench SHALL drive r0 with op 01111 -> rsp_err=1, rsp_y=0, rsp_zero=1; a following SRA 0x80000000 by 2 gives 0xE0000000 with rsp_err=0.
REQ-037 The bench SHALL run the RR_EN=0 build with both requesters valid for 4 cycles -> requester 0 wins all 4 cycles.
REQ-038 The bench SHALL assert rst for one cycle while FULL -> next cycle rsp_valid=0 and all rsp_* = 0, and the first tie afterwards is granted to requester 0.
